// File: rtl/flight_sequencer_if.sv
// Signal bundle around flight_sequencer: IMU status, controller start/complete
// handshakes, pilot arming inputs and the motor/sequence status outputs.
interface flight_sequencer_if #(
  parameter int REC_VAL_BIT_WIDTH = 8
);
  logic                         imu_good;
  logic                         imu_valid_strobe;
  logic                         ac_complete;
  logic                         bf_complete;
  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val;
  logic                         arm_request;
  logic                         ac_start;
  logic                         bf_start;
  logic                         mixer_latch;
  logic                         motors_enable;
  logic                         fault;
  logic [2:0]                   seq_state;
  logic [7:0]                   overrun_count;

  modport master (
    output imu_good, imu_valid_strobe, ac_complete, bf_complete,
           throttle_val, arm_request,
    input  ac_start, bf_start, mixer_latch, motors_enable, fault,
           seq_state, overrun_count
  );

  modport slave (
    input  imu_good, imu_valid_strobe, ac_complete, bf_complete,
           throttle_val, arm_request,
    output ac_start, bf_start, mixer_latch, motors_enable, fault,
           seq_state, overrun_count
  );
endinterface

// File: rtl/flight_sequencer.sv
// Per-sample scheduler: IMU strobe -> angle controller -> body frame controller
// -> mixer latch, with stage timeout, overrun counting and motor arming.
module flight_sequencer #(
  parameter int                           STAGE_TIMEOUT_US  = 2000,
  parameter int                           ARM_HOLD_US       = 500000,
  parameter int                           REC_VAL_BIT_WIDTH = 8,
  parameter logic [REC_VAL_BIT_WIDTH-1:0] THROTTLE_ARM_MAX  = 8'd10,
  parameter int                           TIMER_WIDTH       = 20
) (
  input  logic               us_clk,
  input  logic               reset,
  flight_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_WAIT_AC = 3'd1,
    SEQ_WAIT_BF = 3'd2,
    SEQ_LATCH   = 3'd3,
    SEQ_FAULT   = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    ARM_DISARMED = 2'd0,
    ARM_ARMING   = 2'd1,
    ARM_ARMED    = 2'd2
  } arm_state_t;

  localparam logic [TIMER_WIDTH-1:0] STAGE_LIMIT = TIMER_WIDTH'(STAGE_TIMEOUT_US - 1);
  localparam logic [TIMER_WIDTH-1:0] ARM_LIMIT   = TIMER_WIDTH'(ARM_HOLD_US - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);

  seq_state_t             seq_q, seq_d;
  arm_state_t             arm_q, arm_d;
  logic [TIMER_WIDTH-1:0] stage_timer_q, stage_timer_d;
  logic [TIMER_WIDTH-1:0] arm_timer_q, arm_timer_d;
  logic [7:0]             overrun_q, overrun_d;
  logic                   ac_start_q, bf_start_q, mixer_latch_q;
  logic                   motors_enable_q, fault_q;
  logic                   fault_d;
  logic                   arm_hold_ok, arm_entry_ok;
  logic                   seq_busy;

  // Sequence FSM; ac_start_q marks the first WAIT_AC cycle, where a complete is not yet sampled.
  always_comb begin
    seq_d         = seq_q;
    stage_timer_d = '0;
    case (seq_q)
      SEQ_IDLE: begin
        if (bus.imu_valid_strobe && bus.imu_good) seq_d = SEQ_WAIT_AC;
      end
      SEQ_WAIT_AC: begin
        if (bus.ac_complete && !ac_start_q)  seq_d = SEQ_WAIT_BF;
        else if (stage_timer_q == STAGE_LIMIT) seq_d = SEQ_FAULT;
        else stage_timer_d = stage_timer_q + TIMER_ONE;
      end
      SEQ_WAIT_BF: begin
        if (bus.bf_complete)                   seq_d = SEQ_LATCH;
        else if (stage_timer_q == STAGE_LIMIT) seq_d = SEQ_FAULT;
        else stage_timer_d = stage_timer_q + TIMER_ONE;
      end
      SEQ_LATCH: seq_d = SEQ_IDLE;
      SEQ_FAULT: begin
        if (!bus.arm_request) seq_d = SEQ_IDLE;
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  assign fault_d  = (seq_d == SEQ_FAULT);
  assign seq_busy = (seq_q == SEQ_WAIT_AC) || (seq_q == SEQ_WAIT_BF) || (seq_q == SEQ_LATCH);

  always_comb begin
    overrun_d = overrun_q;
    if (bus.imu_valid_strobe && seq_busy && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
  end

  // The arm FSM sees the upcoming fault so motors drop on the same edge the sequencer faults.
  assign arm_hold_ok  = bus.arm_request && bus.imu_good && !fault_d;
  assign arm_entry_ok = arm_hold_ok && (bus.throttle_val <= THROTTLE_ARM_MAX);

  always_comb begin
    arm_d       = arm_q;
    arm_timer_d = '0;
    case (arm_q)
      ARM_DISARMED: begin
        if (arm_entry_ok) arm_d = ARM_ARMING;
      end
      ARM_ARMING: begin
        if (!arm_entry_ok)                arm_d = ARM_DISARMED;
        else if (arm_timer_q == ARM_LIMIT) arm_d = ARM_ARMED;
        else arm_timer_d = arm_timer_q + TIMER_ONE;
      end
      ARM_ARMED: begin
        if (!arm_hold_ok) arm_d = ARM_DISARMED;
      end
      default: arm_d = ARM_DISARMED;
    endcase
  end

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      seq_q           <= SEQ_IDLE;
      arm_q           <= ARM_DISARMED;
      stage_timer_q   <= '0;
      arm_timer_q     <= '0;
      overrun_q       <= '0;
      ac_start_q      <= 1'b0;
      bf_start_q      <= 1'b0;
      mixer_latch_q   <= 1'b0;
      motors_enable_q <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      seq_q           <= seq_d;
      arm_q           <= arm_d;
      stage_timer_q   <= stage_timer_d;
      arm_timer_q     <= arm_timer_d;
      overrun_q       <= overrun_d;
      ac_start_q      <= (seq_q == SEQ_IDLE)    && (seq_d == SEQ_WAIT_AC);
      bf_start_q      <= (seq_q == SEQ_WAIT_AC) && (seq_d == SEQ_WAIT_BF);
      mixer_latch_q   <= (seq_d == SEQ_LATCH);
      motors_enable_q <= (arm_d == ARM_ARMED);
      fault_q         <= fault_d;
    end
  end

  assign bus.ac_start      = ac_start_q;
  assign bus.bf_start      = bf_start_q;
  assign bus.mixer_latch   = mixer_latch_q;
  assign bus.motors_enable = motors_enable_q;
  assign bus.fault         = fault_q;
  assign bus.seq_state     = seq_q;
  assign bus.overrun_count = overrun_q;

endmodule

// File: tb/tb_flight_sequencer.sv
// Directed bench for flight_sequencer; start/latch pulses are matched against a
// scoreboard of expected (pulse, cycle) pairs, levels are checked inline.
module tb_flight_sequencer;

  localparam int STAGE_TIMEOUT_US = 16;
  localparam int ARM_HOLD_US      = 32;
  localparam logic [1:0] K_AC    = 2'd0;
  localparam logic [1:0] K_BF    = 2'd1;
  localparam logic [1:0] K_LATCH = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
  } pulse_t;

  logic   us_clk = 1'b0;
  logic   reset;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     t0;
  pulse_t exp_q[$];

  flight_sequencer_if #(.REC_VAL_BIT_WIDTH(8)) bus ();

  flight_sequencer #(
    .STAGE_TIMEOUT_US (STAGE_TIMEOUT_US),
    .ARM_HOLD_US      (ARM_HOLD_US),
    .REC_VAL_BIT_WIDTH(8),
    .THROTTLE_ARM_MAX (8'd10),
    .TIMER_WIDTH      (20)
  ) dut (
    .us_clk(us_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 us_clk = ~us_clk;

  always @(posedge us_clk) cyc <= cyc + 1;

  task automatic tickOne();
    @(posedge us_clk);
    #1;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) tickOne();
  endtask

  // Drive the pulse inputs for exactly one cycle.
  task automatic applyStimulus(input logic strobe, input logic acc, input logic bfc);
    bus.imu_valid_strobe = strobe;
    bus.ac_complete      = acc;
    bus.bf_complete      = bfc;
    tickOne();
    bus.imu_valid_strobe = 1'b0;
    bus.ac_complete      = 1'b0;
    bus.bf_complete      = 1'b0;
  endtask

  task automatic expectPulse(input logic [1:0] kind, input int at_cyc);
    pulse_t p;
    p.kind = kind;
    p.cyc  = at_cyc;
    exp_q.push_back(p);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkPulse(input logic [1:0] kind);
    pulse_t got, want;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL unexpected_pulse: observed kind %0d at cycle %0d expected no pulse", kind, cyc);
    end
    if (exp_q.size() != 0) begin
      want     = exp_q.pop_front();
      got.kind = kind;
      got.cyc  = cyc;
      checks++;
      assert (got === want) else begin
        errors++;
        $error("[TB] FAIL pulse_match: observed kind %0d cycle %0d expected kind %0d cycle %0d",
               got.kind, got.cyc, want.kind, want.cyc);
      end
    end
  endtask

  always @(negedge us_clk) begin
    if (bus.ac_start === 1'b1)    checkPulse(K_AC);
    if (bus.bf_start === 1'b1)    checkPulse(K_BF);
    if (bus.mixer_latch === 1'b1) checkPulse(K_LATCH);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset                = 1'b1;
    bus.imu_good         = 1'b0;
    bus.imu_valid_strobe = 1'b0;
    bus.ac_complete      = 1'b0;
    bus.bf_complete      = 1'b0;
    bus.arm_request      = 1'b0;
    bus.throttle_val     = 8'd0;
    tickOne();
    tickOne();
    checkOutput("reset_seq_state", bus.seq_state, 0);
    checkOutput("reset_overrun", bus.overrun_count, 0);
    checkOutput("reset_motors", bus.motors_enable, 0);
    checkOutput("reset_fault", bus.fault, 0);
    checkOutput("reset_pulses", {bus.ac_start, bus.bf_start, bus.mixer_latch}, 0);
    reset = 1'b0;
    tickOne();

    $display("[TB] ignored inputs while idle");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("strobe_no_imu_state", bus.seq_state, 0);
    bus.imu_good = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("stray_complete_state", bus.seq_state, 0);

    $display("[TB] nominal sequence");
    t0 = cyc;
    expectPulse(K_AC, t0 + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("nom_wait_ac", bus.seq_state, 1);
    stepTo(t0 + 4);
    expectPulse(K_BF, t0 + 5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("nom_wait_bf", bus.seq_state, 2);
    stepTo(t0 + 7);
    expectPulse(K_LATCH, t0 + 8);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("nom_latch", bus.seq_state, 3);
    tickOne();
    checkOutput("nom_idle", bus.seq_state, 0);
    checkOutput("nom_fault", bus.fault, 0);
    checkOutput("nom_overrun", bus.overrun_count, 0);

    $display("[TB] stage timeout");
    bus.arm_request = 1'b1;
    t0 = cyc;
    expectPulse(K_AC, t0 + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepTo(t0 + 16);
    checkOutput("to_before_state", bus.seq_state, 1);
    checkOutput("to_before_fault", bus.fault, 0);
    tickOne();
    checkOutput("to_fault_state", bus.seq_state, 4);
    checkOutput("to_fault_flag", bus.fault, 1);
    checkOutput("to_fault_motors", bus.motors_enable, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tickOne();
    checkOutput("to_fault_holds", bus.seq_state, 4);
    checkOutput("to_strobe_not_counted", bus.overrun_count, 0);
    bus.arm_request = 1'b0;
    tickOne();
    checkOutput("to_exit_state", bus.seq_state, 0);
    checkOutput("to_exit_fault", bus.fault, 0);

    $display("[TB] overrun counting");
    t0 = cyc;
    expectPulse(K_AC, t0 + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepTo(t0 + 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ovr_two", bus.overrun_count, 2);
    stepTo(t0 + 10);
    expectPulse(K_BF, t0 + 11);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectPulse(K_LATCH, t0 + 12);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tickOne();
    checkOutput("ovr_seq_done", bus.seq_state, 0);
    checkOutput("ovr_still_two", bus.overrun_count, 2);
    for (int i = 0; i < 20; i++) begin
      t0 = cyc;
      expectPulse(K_AC, t0 + 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (14) applyStimulus(1'b1, 1'b0, 1'b0);
      expectPulse(K_BF, t0 + 16);
      applyStimulus(1'b1, 1'b1, 1'b0);
      expectPulse(K_LATCH, t0 + 17);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tickOne();
      if (i == 0) checkOutput("ovr_seventeen", bus.overrun_count, 17);
    end
    checkOutput("ovr_saturated", bus.overrun_count, 255);
    checkOutput("ovr_no_fault", bus.fault, 0);

    $display("[TB] arming");
    bus.throttle_val = 8'd5;
    bus.arm_request  = 1'b1;
    t0 = cyc;
    stepTo(t0 + 32);
    checkOutput("arm_not_yet", bus.motors_enable, 0);
    tickOne();
    checkOutput("arm_armed", bus.motors_enable, 1);
    bus.arm_request = 1'b0;
    tickOne();
    checkOutput("arm_release", bus.motors_enable, 0);
    bus.throttle_val = 8'd11;
    bus.arm_request  = 1'b1;
    repeat (40) tickOne();
    checkOutput("arm_high_throttle", bus.motors_enable, 0);
    bus.arm_request = 1'b0;
    tickOne();
    bus.throttle_val = 8'd10;
    bus.arm_request  = 1'b1;
    t0 = cyc;
    stepTo(t0 + 10);
    bus.arm_request = 1'b0;
    tickOne();
    bus.arm_request = 1'b1;
    stepTo(t0 + 33);
    checkOutput("arm_restart_early", bus.motors_enable, 0);
    stepTo(t0 + 43);
    checkOutput("arm_restart_not_yet", bus.motors_enable, 0);
    tickOne();
    checkOutput("arm_restart_armed", bus.motors_enable, 1);

    $display("[TB] disarm sources");
    bus.throttle_val = 8'd255;
    repeat (5) tickOne();
    checkOutput("armed_throttle_max", bus.motors_enable, 1);
    bus.imu_good = 1'b0;
    tickOne();
    checkOutput("disarm_imu", bus.motors_enable, 0);
    bus.imu_good     = 1'b1;
    bus.throttle_val = 8'd0;
    t0 = cyc;
    stepTo(t0 + 33);
    checkOutput("rearmed", bus.motors_enable, 1);
    t0 = cyc;
    expectPulse(K_AC, t0 + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepTo(t0 + 16);
    checkOutput("fault_pre_motors", bus.motors_enable, 1);
    tickOne();
    checkOutput("disarm_fault_motors", bus.motors_enable, 0);
    checkOutput("disarm_fault_flag", bus.fault, 1);
    bus.arm_request = 1'b0;
    tickOne();
    checkOutput("disarm_fault_exit", bus.seq_state, 0);

    $display("[TB] async reset in WAIT_BF");
    t0 = cyc;
    expectPulse(K_AC, t0 + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepTo(t0 + 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_state", bus.seq_state, 2);
    checkOutput("pre_reset_bf_start", bus.bf_start, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_seq_state", bus.seq_state, 0);
    checkOutput("async_bf_start", bus.bf_start, 0);
    checkOutput("async_overrun", bus.overrun_count, 0);
    checkOutput("async_fault_motors", {bus.fault, bus.motors_enable}, 0);
    @(posedge us_clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tickOne();
    tickOne();
    checkOutput("post_reset_state", bus.seq_state, 0);
    checkOutput("post_reset_latch", bus.mixer_latch, 0);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
